ddr3_init_seq: RTL and testbench

- Power-up and initialisation sequencer for the on-board x16 DDR3 device; sits directly upstream of the DDR3 pins driven out of the wiggle top level.
- After reset, it steps through the JEDEC reset/CKE/MRS/ZQCL sequence on the ddr3_* command/address pins, then asserts init_done.
- After init_done, the command mux in front of the pins hands control to the memory controller.

---
 rtl/ddr3_init_seq.sv | 157 +++++++++++++++
 tb/tb_ddr3_init_seq.sv | 115 +++++++++++
 2 files changed

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: reset hold, CKE wait, tXPR, MR2/MR3/MR1/MR0, ZQCL, then init_done.
// Outputs are registered from the current state, so each state's commands appear one edge after the state is entered.
module ddr3_init_seq #(
  parameter int          T_RST   = 10000,
  parameter int          T_CKE   = 25000,
  parameter int          T_XPR   = 10,
  parameter int          T_MRD   = 4,
  parameter int          T_MOD   = 12,
  parameter int          T_ZQ    = 512,
  parameter logic [12:0] MR0_VAL = 13'h0520,
  parameter logic [12:0] MR1_VAL = 13'h0004,
  parameter logic [12:0] MR2_VAL = 13'h0000,
  parameter logic [12:0] MR3_VAL = 13'h0000
) (
  input  logic        osc,
  input  logic        rst,
  output logic        ddr3_rstn,
  output logic        ddr3_cke,
  output logic        ddr3_csn,
  output logic        ddr3_rasn,
  output logic        ddr3_casn,
  output logic        ddr3_wen,
  output logic [2:0]  ddr3_ba,
  output logic [12:0] ddr3_a,
  output logic        ddr3_odt,
  output logic        init_done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(max2(T_RST, T_CKE), max2(T_XPR, T_MRD)), max2(T_MOD, T_ZQ));
  localparam int CW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [3:0] {
    RST_HOLD, CKE_WAIT, XPR_WAIT, MRS2, MRS3, MRS1, MRS0, ZQCL, DONE
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_load;
  logic          r_first;
  logic          w_expire;

  logic        w_rstn, w_cke, w_csn, w_rasn, w_casn, w_wen, w_done;
  logic [2:0]  w_ba;
  logic [12:0] w_a;

  // Next state and the counter reload value for the state being entered.
  always_comb begin
    w_next   = r_state;
    w_expire = (r_cnt == '0) && (r_state != DONE);
    if (w_expire) begin
      case (r_state)
        RST_HOLD: w_next = CKE_WAIT;
        CKE_WAIT: w_next = XPR_WAIT;
        XPR_WAIT: w_next = MRS2;
        MRS2:     w_next = MRS3;
        MRS3:     w_next = MRS1;
        MRS1:     w_next = MRS0;
        MRS0:     w_next = ZQCL;
        ZQCL:     w_next = DONE;
        default:  w_next = DONE;
      endcase
    end
    case (w_next)
      CKE_WAIT:          w_load = CW'(T_CKE - 1);
      XPR_WAIT:          w_load = CW'(T_XPR - 1);
      MRS2, MRS3, MRS1:  w_load = CW'(T_MRD - 1);
      MRS0:              w_load = CW'(T_MOD - 1);
      ZQCL:              w_load = CW'(T_ZQ - 1);
      default:           w_load = CW'(T_RST - 1);
    endcase
  end

  // Pin decode; the MRS/ZQCL command occupies only the first cycle of its state.
  always_comb begin
    w_rstn = 1'b0;
    w_cke  = 1'b0;
    w_csn  = 1'b1;
    w_rasn = 1'b1;
    w_casn = 1'b1;
    w_wen  = 1'b1;
    w_ba   = 3'd0;
    w_a    = 13'd0;
    w_done = 1'b0;
    case (r_state)
      RST_HOLD: ;
      CKE_WAIT: w_rstn = 1'b1;
      default: begin
        w_rstn = 1'b1;
        w_cke  = 1'b1;
        w_csn  = 1'b0;
        if (r_first) begin
          case (r_state)
            MRS2: begin w_ba = 3'd2; w_a = MR2_VAL; end
            MRS3: begin w_ba = 3'd3; w_a = MR3_VAL; end
            MRS1: begin w_ba = 3'd1; w_a = MR1_VAL; end
            MRS0: begin w_ba = 3'd0; w_a = MR0_VAL; end
            default: ;
          endcase
          case (r_state)
            MRS2, MRS3, MRS1, MRS0: begin
              w_rasn = 1'b0;
              w_casn = 1'b0;
              w_wen  = 1'b0;
            end
            ZQCL: begin
              w_wen = 1'b0;
              w_a   = 13'h0400;
            end
            default: ;
          endcase
        end
        w_done = (r_state == DONE);
      end
    endcase
  end

  always_ff @(posedge osc) begin
    if (rst) begin
      r_state   <= RST_HOLD;
      r_cnt     <= CW'(T_RST - 1);
      r_first   <= 1'b1;
      ddr3_rstn <= 1'b0;
      ddr3_cke  <= 1'b0;
      ddr3_csn  <= 1'b1;
      ddr3_rasn <= 1'b1;
      ddr3_casn <= 1'b1;
      ddr3_wen  <= 1'b1;
      ddr3_ba   <= 3'd0;
      ddr3_a    <= 13'd0;
      init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_expire) begin
        r_cnt   <= w_load;
        r_first <= 1'b1;
      end else begin
        if (r_state != DONE) r_cnt <= r_cnt - 1'b1;
        r_first <= 1'b0;
      end
      ddr3_rstn <= w_rstn;
      ddr3_cke  <= w_cke;
      ddr3_csn  <= w_csn;
      ddr3_rasn <= w_rasn;
      ddr3_casn <= w_casn;
      ddr3_wen  <= w_wen;
      ddr3_ba   <= w_ba;
      ddr3_a    <= w_a;
      init_done <= w_done;
    end
  end

  assign ddr3_odt = 1'b0;

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Scoreboard bench for ddr3_init_seq with small timing parameters.
// Expected pin vectors come from a timeline model built from the phase lengths.
module tb_ddr3_init_seq;

  localparam int T_RST = 8, T_CKE = 10, T_XPR = 5, T_MRD = 4, T_MOD = 12, T_ZQ = 16;
  localparam logic [12:0] MR0 = 13'h0520, MR1 = 13'h0004, MR2 = 13'h0000, MR3 = 13'h0000;

  logic        osc, rst;
  logic        ddr3_rstn, ddr3_cke, ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen, ddr3_odt, init_done;
  logic [2:0]  ddr3_ba;
  logic [12:0] ddr3_a;

  ddr3_init_seq #(
    .T_RST(T_RST), .T_CKE(T_CKE), .T_XPR(T_XPR), .T_MRD(T_MRD), .T_MOD(T_MOD), .T_ZQ(T_ZQ),
    .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3)
  ) dut (
    .osc(osc), .rst(rst),
    .ddr3_rstn(ddr3_rstn), .ddr3_cke(ddr3_cke), .ddr3_csn(ddr3_csn),
    .ddr3_rasn(ddr3_rasn), .ddr3_casn(ddr3_casn), .ddr3_wen(ddr3_wen),
    .ddr3_ba(ddr3_ba), .ddr3_a(ddr3_a), .ddr3_odt(ddr3_odt), .init_done(init_done)
  );

  initial osc = 1'b0;
  always #5 osc = ~osc;

  // {rstn, cke, csn, rasn, casn, wen, ba[2:0], a[12:0], odt, done}
  localparam logic [23:0] RST_VEC = {1'b0, 1'b0, 4'b1111, 3'd0, 13'd0, 1'b0, 1'b0};

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int mrs_cnt = 0, zq_cnt = 0;
  logic prev_done = 1'b0, prev_rstn = 1'b0, prev_cke = 1'b0;
  logic [23:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic rstn, input logic cke, input logic [3:0] cmd,
                                     input logic [2:0] ba, input logic [12:0] a, input logic done);
    return {rstn, cke, cmd, ba, a, 1'b0, done};
  endfunction

  // Expected pins at cycle c counted from reset release.
  function automatic logic [23:0] exp_at(input int c);
    int b_cke, b_xpr, m2, m3, m1, m0, zq, dn;
    logic [3:0] nop;
    b_cke = T_RST;
    b_xpr = b_cke + T_CKE;
    m2 = b_xpr + T_XPR;
    m3 = m2 + T_MRD;
    m1 = m3 + T_MRD;
    m0 = m1 + T_MRD;
    zq = m0 + T_MOD;
    dn = zq + T_ZQ;
    nop = (c >= b_xpr) ? 4'b0111 : 4'b1111;
    if (c == m2) return mk(1'b1, 1'b1, 4'b0000, 3'd2, MR2, 1'b0);
    if (c == m3) return mk(1'b1, 1'b1, 4'b0000, 3'd3, MR3, 1'b0);
    if (c == m1) return mk(1'b1, 1'b1, 4'b0000, 3'd1, MR1, 1'b0);
    if (c == m0) return mk(1'b1, 1'b1, 4'b0000, 3'd0, MR0, 1'b0);
    if (c == zq) return mk(1'b1, 1'b1, 4'b0110, 3'd0, 13'h0400, 1'b0);
    return mk(c >= b_cke, c >= b_xpr, nop, 3'd0, 13'd0, c >= dn);
  endfunction

  task automatic step(input logic r);
    logic [23:0] e, got;
    int c;
    @(negedge osc);
    rst = r;
    if (r) begin
      e = RST_VEC; c = -1; cyc = 0;
    end else begin
      c = cyc; e = exp_at(cyc); cyc++;
    end
    sb.push_back(e);
    @(posedge osc);
    #1;
    got = {ddr3_rstn, ddr3_cke, ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen, ddr3_ba, ddr3_a, ddr3_odt, init_done};
    e = sb.pop_front();
    chk($sformatf("pins@%0d", c), {8'd0, got}, {8'd0, e});
    if (r) begin
      mrs_cnt = 0; zq_cnt = 0;
    end else begin
      if ({ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen} == 4'b0000) mrs_cnt++;
      if ({ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen} == 4'b0110) zq_cnt++;
      if (ddr3_rstn && !prev_rstn) chk("rstn_rise_cyc", c, 8);
      if (ddr3_cke && !prev_cke)   chk("cke_rise_cyc", c, 18);
      if (init_done && !prev_done) begin
        chk("done_rise_cyc", c, 63);
        chk("mrs_count", mrs_cnt, 4);
        chk("zqcl_count", zq_cnt, 1);
      end
    end
    prev_done = init_done; prev_rstn = ddr3_rstn; prev_cke = ddr3_cke;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step(1'b1);
    repeat (30) step(1'b0);   // cycles 0..29, interrupted inside MRS3
    step(1'b1);               // single-cycle reset at cycle 30
    repeat (100) step(1'b0);  // full pass, then idle in DONE
    step(1'b1);               // single-cycle reset while in DONE
    repeat (70) step(1'b0);
    repeat (50) step(1'b1);   // long reset: everything parked
    repeat (5) step(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
